// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, the I/D cache requesters and the shared memory port.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned LINE_W = WORD_SIZE * LINE_WORDS;

    logic                 i_read;
    logic [WORD_SIZE-1:0] i_address;
    logic [LINE_W-1:0]    i_rdata;
    logic                 i_ready;

    logic                 d_read;
    logic                 d_write;
    logic [WORD_SIZE-1:0] d_address;
    logic [LINE_W-1:0]    d_wdata;
    logic [LINE_W-1:0]    d_rdata;
    logic                 d_ready;

    logic                 m_read;
    logic                 m_write;
    logic [WORD_SIZE-1:0] m_address;
    logic [LINE_W-1:0]    m_wdata;
    logic [LINE_W-1:0]    m_rdata;
    logic                 m_ready;

    // Arbiter side
    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, m_rdata, m_ready,
        output i_rdata, i_ready, d_rdata, d_ready, m_read, m_write, m_address, m_wdata
    );

    // Cache/memory environment side
    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, m_read, m_write, m_address, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) line-fill and write-back arbiter onto one memory port.
// Round-robin on ties, fully registered outputs, one-cycle ready pulse per transaction.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus,
    output logic          busy,
    output logic [15:0]   conflict_cnt
);
    localparam int unsigned LINE_W = WORD_SIZE * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;

    state_t               state_q, state_d;
    grant_t               last_q, last_d;
    grant_t               cur_q, cur_d;
    logic                 m_read_q, m_read_d;
    logic                 m_write_q, m_write_d;
    logic [WORD_SIZE-1:0] m_address_q, m_address_d;
    logic [LINE_W-1:0]    m_wdata_q, m_wdata_d;
    logic [LINE_W-1:0]    i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]    d_rdata_q, d_rdata_d;
    logic                 i_ready_q, i_ready_d;
    logic                 d_ready_q, d_ready_d;
    logic                 busy_q, busy_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 i_req, d_req;

    always_comb begin
        i_req       = bus.i_read;
        d_req       = bus.d_read | bus.d_write;
        state_d     = state_q;
        last_d      = last_q;
        cur_d       = cur_q;
        m_read_d    = m_read_q;
        m_write_d   = m_write_q;
        m_address_d = m_address_q;
        m_wdata_d   = m_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_req && d_req && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
                // I wins when alone, or on a tie when D was served last.
                if (i_req && (!d_req || (last_q == GNT_D))) begin
                    state_d     = MEM_I;
                    cur_d       = GNT_I;
                    m_read_d    = 1'b1;
                    m_write_d   = 1'b0;
                    m_address_d = bus.i_address;
                end else if (d_req) begin
                    state_d     = MEM_D;
                    cur_d       = GNT_D;
                    m_read_d    = ~bus.d_write;
                    m_write_d   = bus.d_write;
                    m_address_d = bus.d_address;
                    m_wdata_d   = bus.d_wdata;
                end
            end
            MEM_I, MEM_D: begin
                if (bus.m_ready) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == MEM_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!m_write_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = cur_q;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= GNT_D;
            cur_q       <= GNT_I;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_q       <= cur_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            m_address_q <= m_address_d;
            m_wdata_q   <= m_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.m_read    = m_read_q;
    assign bus.m_write   = m_write_q;
    assign bus.m_address = m_address_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign busy          = busy_q;
    assign conflict_cnt  = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then random cache/memory traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam logic [63:0] RD1  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] JUNK = 64'hAAAA_5555_AAAA_5555;
    localparam logic [63:0] WD1  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] WD2  = 64'h0F0F_F0F0_1234_5678;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [15:0] conflict_cnt;
    int          n_checks;
    int          n_errors;

    mem_arbiter_if #(.WORD_SIZE(16), .LINE_WORDS(4)) bus ();

    mem_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        i_rd;
        logic [15:0] i_a;
        logic        d_rd;
        logic        d_wr;
        logic [15:0] d_a;
        logic [63:0] d_wd;
        logic        m_rdy;
        logic [63:0] m_rd;
        logic [4:0]  ctl;   // {busy, m_read, m_write, i_ready, d_ready}
        logic [1:0]  kind;  // 0 none, 1 memory request, 2 i_rdata, 3 d_rdata
        logic [15:0] addr;
        logic [63:0] data;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.m_ready   = 1'b0;
        bus.m_rdata   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mready(input logic [63:0] data);
        bus.m_ready = 1'b1;
        bus.m_rdata = data;
        step();
        bus.m_ready = 1'b0;
    endtask

    // Reference model state: transaction phase 0 idle, 1 memory access, 2 response.
    int          ph;
    logic        last_d, own_d, e_wr;
    logic        e_busy, e_mr, e_mw, e_ir, e_dr;
    logic [15:0] e_addr, e_cnt;
    logic [63:0] e_wdata, e_ird, e_drd;
    int          mem_wait;

    task automatic model_reset();
        ph = 0; last_d = 1'b1; own_d = 1'b0; e_wr = 1'b0;
        e_busy = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_addr = '0; e_cnt = '0; e_wdata = '0; e_ird = '0; e_drd = '0;
    endtask

    task automatic model_step();
        logic ireq, dreq;
        ireq = bus.i_read;
        dreq = bus.d_read | bus.d_write;
        case (ph)
            0: begin
                if (ireq && dreq && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
                if (ireq || dreq) begin
                    own_d  = (ireq && dreq) ? !last_d : dreq;
                    e_wr   = own_d && bus.d_write;
                    e_addr = own_d ? bus.d_address : bus.i_address;
                    if (own_d) e_wdata = bus.d_wdata;
                    e_mr = !e_wr; e_mw = e_wr; e_busy = 1'b1;
                    ph = 1;
                end
            end
            1: begin
                if (bus.m_ready) begin
                    e_mr = 1'b0; e_mw = 1'b0;
                    if (own_d) begin
                        e_dr = 1'b1;
                        if (!e_wr) e_drd = bus.m_rdata;
                    end else begin
                        e_ir = 1'b1;
                        e_ird = bus.m_rdata;
                    end
                    ph = 2;
                end
            end
            default: begin
                e_ir = 1'b0; e_dr = 1'b0; e_busy = 1'b0;
                last_d = own_d;
                ph = 0;
            end
        endcase
    endtask

    task automatic model_compare();
        check("rnd_busy", 64'(busy), 64'(e_busy));
        check("rnd_m_read", 64'(bus.m_read), 64'(e_mr));
        check("rnd_m_write", 64'(bus.m_write), 64'(e_mw));
        check("rnd_i_ready", 64'(bus.i_ready), 64'(e_ir));
        check("rnd_d_ready", 64'(bus.d_ready), 64'(e_dr));
        check("rnd_conflict", 64'(conflict_cnt), 64'(e_cnt));
        check("rnd_d_rdata", bus.d_rdata, e_drd);
        if (e_mr || e_mw) check("rnd_m_address", 64'(bus.m_address), 64'(e_addr));
        if (e_mw) check("rnd_m_wdata", bus.m_wdata, e_wdata);
        if (e_ir) check("rnd_i_rdata", bus.i_rdata, e_ird);
    endtask

    task automatic random_drive();
        if ($urandom_range(0, 3) == 0) begin
            bus.i_read = ~bus.i_read;
            if (bus.i_read) bus.i_address = 16'($urandom);
        end
        if ($urandom_range(0, 3) == 0) begin
            {bus.d_read, bus.d_write} = 2'($urandom_range(0, 3));
            bus.d_address = 16'($urandom);
            bus.d_wdata   = {$urandom, $urandom};
        end
        bus.m_rdata = {$urandom, $urandom};
        if (bus.m_read || bus.m_write) begin
            if (mem_wait < 0) mem_wait = int'($urandom_range(0, 3));
            if (mem_wait == 0) begin
                bus.m_ready = 1'b1;
            end else begin
                bus.m_ready = 1'b0;
                mem_wait--;
            end
        end else begin
            mem_wait = -1;
            bus.m_ready = ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        int pulses;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;

        tbl[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b0, 64'h0, 5'b11000, 2'd1, 16'h0010, 64'h0};
        tbl[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b0, 64'h0, 5'b11000, 2'd1, 16'h0010, 64'h0};
        tbl[2]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b0, 64'h0, 5'b11000, 2'd1, 16'h0010, 64'h0};
        tbl[3]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b1, RD1,   5'b10010, 2'd2, 16'h0000, RD1};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b0, 64'h0, 5'b00000, 2'd0, 16'h0000, 64'h0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0024, WD1,   1'b0, 64'h0, 5'b10100, 2'd1, 16'h0024, WD1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0024, WD1,   1'b0, 64'h0, 5'b10100, 2'd1, 16'h0024, WD1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0024, WD1,   1'b1, JUNK,  5'b10001, 2'd3, 16'h0000, 64'h0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b0, 64'h0, 5'b00000, 2'd0, 16'h0000, 64'h0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, WD2,   1'b0, 64'h0, 5'b10100, 2'd1, 16'h0030, WD2};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, WD2,   1'b1, JUNK,  5'b10001, 2'd3, 16'h0000, 64'h0};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b1, JUNK,  5'b00000, 2'd0, 16'h0000, 64'h0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b1, JUNK,  5'b00000, 2'd0, 16'h0000, 64'h0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 64'h0, 1'b0, 64'h0, 5'b11000, 2'd1, 16'h0040, 64'h0};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 64'h0, 1'b1, RD1,   5'b10001, 2'd3, 16'h0000, RD1};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 64'h0, 1'b0, 64'h0, 5'b00000, 2'd0, 16'h0000, 64'h0};

        // Reset state
        do_reset();
        check("rst_outputs", 64'({busy, bus.m_read, bus.m_write, bus.i_ready, bus.d_ready}), 64'h0);
        check("rst_conflict", 64'(conflict_cnt), 64'h0);
        check("rst_m_address", 64'(bus.m_address), 64'h0);
        check("rst_i_rdata", bus.i_rdata, 64'h0);
        check("rst_d_rdata", bus.d_rdata, 64'h0);

        // Directed vector table
        for (int r = 0; r < 16; r++) begin
            bus.i_read    = tbl[r].i_rd;
            bus.i_address = tbl[r].i_a;
            bus.d_read    = tbl[r].d_rd;
            bus.d_write   = tbl[r].d_wr;
            bus.d_address = tbl[r].d_a;
            bus.d_wdata   = tbl[r].d_wd;
            bus.m_ready   = tbl[r].m_rdy;
            bus.m_rdata   = tbl[r].m_rd;
            step();
            check($sformatf("vec%0d_ctl", r),
                  64'({busy, bus.m_read, bus.m_write, bus.i_ready, bus.d_ready}), 64'(tbl[r].ctl));
            case (tbl[r].kind)
                2'd1: begin
                    check($sformatf("vec%0d_m_address", r), 64'(bus.m_address), 64'(tbl[r].addr));
                    if (tbl[r].ctl[2]) check($sformatf("vec%0d_m_wdata", r), bus.m_wdata, tbl[r].data);
                end
                2'd2: check($sformatf("vec%0d_i_rdata", r), bus.i_rdata, tbl[r].data);
                2'd3: check($sformatf("vec%0d_d_rdata", r), bus.d_rdata, tbl[r].data);
                default: ;
            endcase
        end
        check("vec_conflict", 64'(conflict_cnt), 64'h0);
        clear_inputs();

        // Tie after reset: I first; I re-requests while D waits, so D wins the next tie.
        do_reset();
        bus.i_read = 1'b1; bus.i_address = 16'h0100;
        bus.d_read = 1'b1; bus.d_address = 16'h0200;
        step();
        check("tie1_m_read", 64'(bus.m_read), 64'h1);
        check("tie1_m_address", 64'(bus.m_address), 64'h0100);
        check("tie1_conflict", 64'(conflict_cnt), 64'h1);
        pulse_mready(64'hA5A5_0000_0000_0001);
        check("tie1_i_ready", 64'(bus.i_ready), 64'h1);
        check("tie1_d_ready", 64'(bus.d_ready), 64'h0);
        check("tie1_i_rdata", bus.i_rdata, 64'hA5A5_0000_0000_0001);
        step();
        check("tie1_idle", 64'({busy, bus.i_ready}), 64'h0);
        step();
        check("tie2_m_address", 64'(bus.m_address), 64'h0200);
        check("tie2_m_read", 64'(bus.m_read), 64'h1);
        check("tie2_conflict", 64'(conflict_cnt), 64'h2);
        pulse_mready(64'h5A5A_0000_0000_0002);
        check("tie2_d_ready", 64'(bus.d_ready), 64'h1);
        check("tie2_i_ready", 64'(bus.i_ready), 64'h0);
        check("tie2_d_rdata", bus.d_rdata, 64'h5A5A_0000_0000_0002);
        bus.d_read = 1'b0;
        step();
        step();
        check("tie3_m_address", 64'(bus.m_address), 64'h0100);
        check("tie3_m_read", 64'(bus.m_read), 64'h1);
        bus.i_read = 1'b0;
        pulse_mready(64'h0);
        check("tie3_i_ready", 64'(bus.i_ready), 64'h1);
        step();

        // Asynchronous reset in the middle of a D access
        do_reset();
        bus.d_read = 1'b1; bus.d_address = 16'h0300;
        step();
        check("rstmid_pre", 64'({busy, bus.m_read}), 64'h3);
        #2;
        reset = 1'b1;
        bus.d_read = 1'b0;
        #1;
        check("rstmid_ctl", 64'({busy, bus.m_read, bus.m_write, bus.i_ready, bus.d_ready}), 64'h0);
        check("rstmid_m_address", 64'(bus.m_address), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.m_ready = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            bus.m_ready = 1'b0;
            pulses += int'(bus.i_ready) + int'(bus.d_ready) + int'(busy);
        end
        check("rstmid_no_activity", 64'(pulses), 64'h0);

        // I request dropped one cycle after grant
        do_reset();
        bus.i_read = 1'b1; bus.i_address = 16'h0500;
        step();
        check("drop_grant", 64'(bus.m_read), 64'h1);
        bus.i_read = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("drop_hold%0d", c), 64'({bus.m_read, bus.m_address}), 64'({1'b1, 16'h0500}));
        end
        pulse_mready(64'hC0FF_EE00_1234_0042);
        check("drop_i_rdata", bus.i_rdata, 64'hC0FF_EE00_1234_0042);
        pulses = int'(bus.i_ready);
        for (int c = 0; c < 3; c++) begin
            step();
            pulses += int'(bus.i_ready);
        end
        check("drop_i_ready_once", 64'(pulses), 64'h1);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        mem_wait = -1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            model_compare();
            random_drive();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16: address width and memory word width.
REQ-002 Parameter LINE_WORDS, default 4: words per cache line; all data ports are LINE_WORDS*WORD_SIZE (64) bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_read  in  1  I-cache line-fill request; held high until i_ready.
REQ-006 i_address  in  16  I-cache line address; stable while i_read is high.
REQ-007 i_rdata  out  64  line returned to I-cache; valid only while i_ready is high.
REQ-008 i_ready  out  1  one-cycle completion pulse to I-cache.
REQ-009 d_read  in  1  D-cache line-fill request.
REQ-010 d_write  in  1  D-cache write-back request.
REQ-011 d_address  in  16  D-cache line address.
REQ-012 d_wdata  in  64  write-back line.
REQ-013 d_rdata  out  64  line returned to D-cache; valid only while d_ready is high.
REQ-014 d_ready  out  1  one-cycle completion pulse to D-cache.
REQ-015 m_read, m_write  out  1 each  request strobes to the single shared memory port.
REQ-016 m_address  out  16  memory address; m_wdata  out  64  memory write line.
REQ-017 m_rdata  in  64  memory read line; m_ready  in  1  one-cycle memory completion pulse.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 conflict_cnt  out  16  saturating count of IDLE cycles with both I and D requests pending.

Function
REQ-020 The FSM SHALL have states IDLE, MEM_I, MEM_D and RESP; all outputs are registered.
REQ-021 IDLE: only i_read -> MEM_I; only d_read or d_write -> MEM_D; both -> the requester not granted last; none -> stay.
REQ-022 The last-grant register SHALL reset to D, so the first tie goes to I.
REQ-023 On grant, the arbiter SHALL latch the address, op (read/write) and d_wdata, and drive m_* from the latched values in the next cycle.
REQ-024 If d_read and d_write are both high, the request SHALL be treated as a write.
REQ-025 MEM_I/MEM_D: m_read or m_write stays high and m_address/m_wdata stay stable until m_ready is sampled high.
REQ-026 On m_ready, the arbiter SHALL deassert m_read/m_write, latch m_rdata (reads only), and enter RESP.
REQ-027 RESP: the arbiter SHALL pulse the granted requester's ready for exactly one cycle with rdata valid, update last-grant, then return to IDLE.
REQ-028 Latency: request sampled in IDLE at edge N -> m strobe high after N; m_ready sampled at edge M -> requester ready high after M, for one cycle; IDLE after M+1.
REQ-029 A requester that still holds its request in the cycle after its ready pulse SHALL be treated as a new request in IDLE.
REQ-030 A requester that drops its request mid-transaction SHALL not abort it; the memory access completes and ready still pulses.
REQ-031 m_ready sampled high in IDLE or RESP SHALL be ignored.
REQ-032 On a write, d_rdata SHALL hold its previous value; only d_ready pulses.
REQ-033 conflict_cnt SHALL increment in each IDLE cycle with i_read and (d_read or d_write) both high, and saturate at 16'hFFFF.
REQ-034 Non-granted ready outputs SHALL remain 0 at all times.

Reset
REQ-035 Reset SHALL immediately force state to IDLE, last-grant to D, all strobes/ready/busy to 0, data outputs and conflict_cnt to 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no ready pulse; a later m_ready is ignored per REQ-031.

Verification
REQ-037 i_read=1, i_address=16'h0010, m_ready pulses 3 cycles after m_read -> m_address=16'h0010, then i_ready one cycle with i_rdata=m_rdata; d_ready=0.
REQ-038 i_read and d_read rise together after reset -> I served first, D second, conflict_cnt=1; repeat the tie -> D served first.
REQ-039 d_write=1, d_address=16'h0024, d_wdata=64'hDEAD_BEEF_0123_4567 -> m_write=1 with matching address/data until m_ready; d_ready pulses; d_rdata unchanged.
REQ-040 d_read=d_write=1 -> memory sees m_write=1, m_read=0.
REQ-041 reset asserted during MEM_D -> all outputs 0 at once; subsequent m_ready produces no ready pulse; busy=0.
REQ-042 i_read dropped one cycle after grant -> m_read held until m_ready; i_ready still pulses once.
